// File: rtl/uart_rx_if.sv
// Shared 32-bit tristate system bus as seen by the UART receiver.
// Drivers are resolved here so that master and slave each own only an enable and a value.
interface uart_rx_if;
  logic [31:0] BUS_addr;
  logic        BUS_req;
  logic        BUS_RW;
  wire  [31:0] BUS_data;
  wire         BUS_ready;

  logic [31:0] mst_wdata;
  logic        mst_drive;
  logic [31:0] slv_rdata;
  logic        slv_data_oe;
  logic        slv_ready_oe;

  assign BUS_data  = mst_drive    ? mst_wdata : 'z;
  assign BUS_data  = slv_data_oe  ? slv_rdata : 'z;
  assign BUS_ready = slv_ready_oe ? 1'b1      : 1'bz;

  modport master (
    output BUS_addr, BUS_req, BUS_RW, mst_wdata, mst_drive,
    input  BUS_data, BUS_ready
  );

  modport slave (
    input  BUS_addr, BUS_req, BUS_RW, BUS_data,
    output slv_rdata, slv_data_oe, slv_ready_oe
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a small receive FIFO, exposed as DATA/STATUS registers on the
// shared system bus, plus a level interrupt while data is pending.
module uart_rx #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
   parameter int unsigned DIV        = 434,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic      clk,
   input  logic      clr,
   uart_rx_if.slave  bus,
   input  logic      RxD,
   output logic      rx_irq
);

   localparam int unsigned TW = $clog2(DIV);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [1:0]      sync_q;
   logic            rxs;
   logic [TW-1:0]   timer_q, timer_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            push_req, frame_err;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            push, pop, ovr_set, not_empty;
   logic            overrun_q, overrun_d, framing_q, framing_d;
   logic            irq_q;

   logic            sel, first, wr_status;
   logic            ready_q, served_q, rw_q;
   logic [31:0]     rdata_q, rd_word, status_word;
   logic [7:0]      count_ext;
   logic            unused_bits;

   assign rxs = sync_q[1];

   // State register and receive datapath
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         sync_q    <= 2'b11;
         state_q   <= StIdle;
         timer_q   <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
      end else begin
         sync_q    <= {sync_q[0], RxD};
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (!rxs) state_d = StStart;
         StStart: if (timer_q == '0) state_d = rxs ? StIdle : StData;
         StData:  if (timer_q == '0 && bit_cnt_q == 3'd7) state_d = StStop;
         StStop:  if (timer_q == '0) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      timer_d   = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      push_req  = 1'b0;
      frame_err = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!rxs) begin
               timer_d   = TW'(DIV / 2 - 1);
               bit_cnt_d = '0;
            end
         end
         StStart: if (timer_q == '0) timer_d = TW'(DIV - 1);
         StData: begin
            if (timer_q == '0) begin
               shift_d   = {rxs, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               timer_d   = TW'(DIV - 1);
            end
         end
         StStop: begin
            if (timer_q == '0) begin
               push_req  = rxs;
               frame_err = !rxs;
            end
         end
         default: ;
      endcase
   end

   // Bus decode; side effects only on the first selected cycle of a transaction
   assign sel       = bus.BUS_req && (bus.BUS_addr[31:1] == BASE_ADDR[31:1]);
   assign first     = sel && !served_q;
   assign not_empty = (count_q != '0);
   assign pop       = first && !bus.BUS_RW && !bus.BUS_addr[0] && not_empty;
   assign wr_status = first && bus.BUS_RW && bus.BUS_addr[0];

   // A pop frees a slot in the same cycle, so a push into a full FIFO still lands
   assign push      = push_req && ((count_q != CW'(FIFO_DEPTH)) || pop);
   assign ovr_set   = push_req && !push;
   assign count_d   = count_q + CW'(push) - CW'(pop);

   assign overrun_d = (overrun_q && !(wr_status && bus.BUS_data[1])) || ovr_set;
   assign framing_d = (framing_q && !(wr_status && bus.BUS_data[2])) || frame_err;

   assign count_ext   = 8'(count_q);
   assign status_word = {24'b0, count_ext[3:0], 1'b0, framing_q, overrun_q, not_empty};
   assign rd_word     = bus.BUS_addr[0] ? status_word
                                        : (not_empty ? {24'b0, mem_q[rd_ptr_q]} : 32'h0);

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= shift_q;
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
         framing_q <= 1'b0;
         irq_q     <= 1'b0;
         ready_q   <= 1'b0;
         served_q  <= 1'b0;
         rw_q      <= 1'b0;
         rdata_q   <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q   <= count_d;
         overrun_q <= overrun_d;
         framing_q <= framing_d;
         irq_q     <= (count_d != '0);
         ready_q   <= sel;
         served_q  <= bus.BUS_req && (served_q || sel);
         if (first) begin
            rw_q    <= bus.BUS_RW;
            rdata_q <= rd_word;
         end
      end
   end

   assign rx_irq           = irq_q;
   assign bus.slv_rdata    = rdata_q;
   assign bus.slv_data_oe  = ready_q && !rw_q;
   assign bus.slv_ready_oe = ready_q;

   assign unused_bits = ^{bus.BUS_data[31:3], bus.BUS_data[0]};

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: serial frames and bus accesses are mirrored by a
// queue-based model of the receiver's register-level behaviour.
module tb_uart_rx;
   localparam int unsigned Div   = 8;
   localparam int unsigned Depth = 4;
   localparam logic [31:0] Base  = 32'h0000_2000;
   localparam logic [31:0] AData = Base;
   localparam logic [31:0] AStat = Base + 32'd1;

   logic clk = 1'b0;
   logic clr = 1'b0;
   logic rxd = 1'b1;
   logic rx_irq;

   uart_rx_if bus ();

   uart_rx #(
      .BASE_ADDR  (Base),
      .DIV        (Div),
      .FIFO_DEPTH (Depth)
   ) dut (
      .clk    (clk),
      .clr    (clr),
      .bus    (bus),
      .RxD    (rxd),
      .rx_irq (rx_irq)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   byte unsigned model_q[$];
   bit m_ovr = 1'b0;
   bit m_frm = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_status();
      return {24'b0, 4'(model_q.size()), 1'b0, m_frm, m_ovr, model_q.size() != 0};
   endfunction

   function automatic logic [31:0] model_read();
      if (model_q.size() == 0) return 32'h0;
      return {24'b0, model_q.pop_front()};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Full 8N1 frame on RxD, bits held Div cycles each, then an idle gap
   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      rxd = 1'b0;
      tick(Div);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(Div);
      end
      rxd = stop_ok;
      tick(Div);
      rxd = 1'b1;
      tick(2 * Div);
      if (!stop_ok) m_frm = 1'b1;
      else if (model_q.size() < Depth) model_q.push_back(b);
      else m_ovr = 1'b1;
   endtask

   task automatic bus_access(input logic [31:0] addr, input bit rw, input logic [31:0] wdata,
                             output logic [31:0] rdata);
      bit got = 1'b0;
      rdata = 32'hDEAD_BEEF;
      bus.BUS_addr  = addr;
      bus.BUS_RW    = rw;
      bus.mst_wdata = wdata;
      bus.mst_drive = rw;
      bus.BUS_req   = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         if (bus.BUS_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check_eq("ready_timeout", 32'(bus.BUS_ready === 1'b1), 32'd1);
      else if (!rw) rdata = bus.BUS_data;
      bus.BUS_req   = 1'b0;
      bus.mst_drive = 1'b0;
      tick(1);
   endtask

   task automatic read_chk(input string tag, input logic [31:0] addr);
      logic [31:0] d, exp;
      exp = (addr == AStat) ? model_status() : model_read();
      bus_access(addr, 1'b0, 32'h0, d);
      check_eq(tag, d, exp);
   endtask

   task automatic write_reg(input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] d;
      bus_access(addr, 1'b1, data, d);
      if (addr == AStat) begin
         if (data[1]) m_ovr = 1'b0;
         if (data[2]) m_frm = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int ready_cnt;
      bus.BUS_addr  = '0;
      bus.BUS_req   = 1'b0;
      bus.BUS_RW    = 1'b0;
      bus.mst_wdata = '0;
      bus.mst_drive = 1'b0;

      tick(3);
      check_eq("reset_irq", 32'(rx_irq), 32'd0);
      check_eq("reset_ready_z", 32'(bus.BUS_ready === 1'b1), 32'd0);
      clr = 1'b1;
      tick(3);
      read_chk("reset_status", AStat);

      // Single byte 0xA5
      send_frame(8'hA5, 1'b1);
      check_eq("a5_status_const", model_status(), 32'h11);
      read_chk("a5_status", AStat);
      check_eq("a5_irq", 32'(rx_irq), 32'd1);
      read_chk("a5_data", AData);
      check_eq("a5_irq_after_pop", 32'(rx_irq), 32'd0);
      read_chk("a5_status_after", AStat);

      // Two-cycle glitch must be rejected at the start-bit check
      rxd = 1'b0;
      tick(2);
      rxd = 1'b1;
      tick(4 * Div);
      read_chk("glitch_status", AStat);

      // Overrun with five bytes into a four-entry FIFO
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      check_eq("ovr_status_const", model_status(), 32'h43);
      read_chk("ovr_status", AStat);
      for (int i = 0; i < 5; i++) read_chk("ovr_data", AData);
      write_reg(AStat, 32'h2);
      read_chk("ovr_cleared", AStat);

      // Framing error
      send_frame(8'h3C, 1'b0);
      check_eq("frm_status_const", model_status(), 32'h04);
      read_chk("frm_status", AStat);
      write_reg(AStat, 32'h4);
      read_chk("frm_cleared", AStat);

      // Held read: one pop, ready for four cycles while request is high
      send_frame(8'h77, 1'b1);
      send_frame(8'h78, 1'b1);
      bus.BUS_addr = AData;
      bus.BUS_RW   = 1'b0;
      bus.BUS_req  = 1'b1;
      ready_cnt = 0;
      repeat (5) begin
         if (bus.BUS_ready === 1'b1) ready_cnt++;
         tick(1);
      end
      check_eq("hold_ready_cycles", 32'(ready_cnt), 32'd4);
      check_eq("hold_data", bus.BUS_data, model_read());
      bus.BUS_req = 1'b0;
      tick(1);
      check_eq("hold_ready_z", 32'(bus.BUS_ready === 1'b1), 32'd0);
      check_eq("hold_data_z", 32'((bus.BUS_data === 32'hz) || (bus.BUS_data === 32'h0)), 32'd1);
      read_chk("hold_status", AStat);

      // Reset in the middle of data bit 4 with a byte already pending
      rxd = 1'b0;
      tick(Div);
      for (int i = 0; i < 4; i++) begin
         rxd = i[0];
         tick(Div);
      end
      rxd = 1'b1;
      tick(Div / 2);
      check_eq("mid_irq_before", 32'(rx_irq), 32'd1);
      clr = 1'b0;
      #1;
      check_eq("mid_irq_reset", 32'(rx_irq), 32'd0);
      model_q.delete();
      m_ovr = 1'b0;
      m_frm = 1'b0;
      tick(2);
      clr = 1'b1;
      tick(2);
      read_chk("mid_status", AStat);
      send_frame(8'h5A, 1'b1);
      read_chk("mid_5a", AData);

      // Randomised mix of frames and register accesses
      for (int n = 0; n < 60; n++) begin
         int op = $urandom_range(0, 9);
         if (op <= 4) send_frame(8'($urandom), $urandom_range(0, 5) != 0);
         else if (op <= 6) read_chk("rnd_data", AData);
         else if (op == 7) read_chk("rnd_status", AStat);
         else if (op == 8) begin
            write_reg(AStat, 32'($urandom_range(0, 7)));
            read_chk("rnd_clear", AStat);
         end else begin
            write_reg(AData, $urandom);
            read_chk("rnd_wdata_ignored", AStat);
         end
         check_eq("rnd_irq", 32'(rx_irq), 32'(model_q.size() != 0));
      end
      while (model_q.size() != 0) read_chk("drain_data", AData);
      read_chk("drain_status", AStat);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end
endmodule
